count_checker: RTL and testbench
================================

COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4, width of the observed count bus.
REQ-002 SHALL have parameter LOCK_CNT, default 3, number of consecutive correct increments required to declare lock (legal range 1..15).
REQ-003 SHALL have parameter ERR_W, default 8, width of the error counter.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, in_count is a sample this cycle.
REQ-007 SHALL have port in_count, input, WIDTH, observed counter value.
REQ-008 SHALL have port locked, output, 1, checker is tracking a valid up-count.
REQ-009 SHALL have port mismatch, output, 1, one-cycle pulse on a sequence break while locked.
REQ-010 SHALL have port err_count, output, ERR_W, number of mismatches, saturating.
REQ-011 SHALL have port expected, output, WIDTH, next value the checker predicts.
REQ-012 SHALL have port wrap_count, output, 8, number of observed wraps (present only with the macro, see REQ-029).

Function
REQ-013 SHALL implement FSM states IDLE, SYNC, LOCKED; all outputs registered, updated one clk after the sampling edge.
REQ-014 SHALL hold all state and outputs unchanged in any cycle with in_valid=0; mismatch SHALL be 0 in such cycles.
REQ-015 IDLE + in_valid: expected <= in_count+1 mod 2^WIDTH, run_len <= 0, go SYNC.
REQ-016 SYNC + in_valid + in_count==expected: run_len++, expected <= in_count+1; when run_len reaches LOCK_CNT go LOCKED and assert locked the same update.
REQ-017 SYNC + in_valid + in_count!=expected: run_len <= 0, expected <= in_count+1, stay SYNC; no mismatch pulse, err_count unchanged.
REQ-018 LOCKED + in_valid + match: expected <= in_count+1, locked stays 1.
REQ-019 LOCKED + in_valid + mismatch: mismatch=1 for exactly one cycle, err_count+1, locked <= 0, run_len <= 0, expected <= in_count+1, go SYNC.
REQ-020 Increment arithmetic SHALL be modulo 2^WIDTH: expected after 4'hF is 4'h0 and 4'h0 following 4'hF is a match.
REQ-021 err_count SHALL saturate at 2^ERR_W-1; further mismatches still pulse mismatch.
REQ-022 A repeated value (in_count==expected-1, stalled counter) SHALL be treated as a mismatch.

Reset
REQ-023 rst SHALL take priority over in_valid in the same cycle.
REQ-024 After the reset edge: state IDLE, locked=0, mismatch=0, err_count=0, expected=0, run_len=0, wrap_count=0.
REQ-025 Reset asserted mid-stream (any state) SHALL discard lock and history; the first valid sample after rst deasserts is handled as in IDLE.
REQ-026 Reset held for multiple cycles SHALL keep all outputs at reset values.

Configuration
REQ-027 Macro COUNT_CHECKER_WRAP_EN SHALL gate wrap counting.
REQ-028 With COUNT_CHECKER_WRAP_EN defined: in LOCKED, a matching sample of value 0 increments wrap_count, modulo 256.
REQ-029 Without it: wrap_count port and its register SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package count_checker_pkg SHALL hold the state typedef (IDLE, SYNC, LOCKED) and the default constants for WIDTH, LOCK_CNT, ERR_W.
REQ-031 Sub-module sat_counter (parameterised width, inc, clear, saturating) SHALL implement err_count; all other logic stays in count_checker.

Verification
REQ-032 rst=1 for 2 cycles, then samples 5,6,7,8 on consecutive valids -> locked=1 after the edge sampling 8, expected=9, err_count=0.
REQ-033 Locked, sample 9 then 3 -> mismatch pulse one cycle, err_count=1, locked=0, expected=4; then 4,5,6 -> locked=1 again.
REQ-034 Locked at 14, samples 15,0,1 -> no mismatch, expected=2; with macro wrap_count=1.
REQ-035 Locked, in_valid=0 for 10 cycles, then next expected value -> no mismatch, locked stays 1.
REQ-036 Locked, rst pulsed for 1 cycle concurrent with a valid wrong sample -> no mismatch, err_count=0, locked=0, state IDLE.
REQ-037 ERR_W=2, force 5 lock/break cycles -> err_count sticks at 3, mismatch pulses all 5 times.

Source files
------------

// File: rtl/count_checker_pkg.sv
// Shared types and default constants for the count_checker block.
package count_checker_pkg;

  localparam int unsigned DefWidth   = 4;
  localparam int unsigned DefLockCnt = 3;
  localparam int unsigned DefErrW    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StLocked
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; synchronous reset and clear.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_checker.sv
// Watches a free-running up-counter, locks after LOCK_CNT clean increments and flags breaks.
// Optional wrap counting is enabled by defining COUNT_CHECKER_WRAP_EN.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned LOCK_CNT = DefLockCnt,
  parameter int unsigned ERR_W    = DefErrW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_count,
  output logic             locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
`ifdef COUNT_CHECKER_WRAP_EN
  output logic [7:0]       wrap_count,
`endif
  output logic [WIDTH-1:0] expected
);

  localparam logic [3:0] LockTarget = 4'(LOCK_CNT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [3:0]       run_q, run_d;
  logic             locked_q, locked_d;
  logic             mism_q, mism_d;
  logic             err_inc;
  logic             match;

  assign match = (in_count == exp_q);

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    run_d    = run_q;
    locked_d = locked_q;
    mism_d   = 1'b0;
    err_inc  = 1'b0;
    if (in_valid) begin
      // Every accepted sample re-seeds the prediction, matched or not.
      exp_d = in_count + WIDTH'(1);
      unique case (state_q)
        StIdle: begin
          run_d    = '0;
          locked_d = 1'b0;
          state_d  = StSync;
        end
        StSync: begin
          if (match) begin
            run_d = run_q + 4'd1;
            if ((run_q + 4'd1) == LockTarget) begin
              locked_d = 1'b1;
              state_d  = StLocked;
            end
          end else begin
            run_d = '0;
          end
        end
        StLocked: begin
          if (!match) begin
            mism_d   = 1'b1;
            err_inc  = 1'b1;
            locked_d = 1'b0;
            run_d    = '0;
            state_d  = StSync;
          end
        end
        default: begin
          run_d    = '0;
          locked_d = 1'b0;
          state_d  = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      exp_q    <= '0;
      run_q    <= '0;
      locked_q <= 1'b0;
      mism_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      run_q    <= run_d;
      locked_q <= locked_d;
      mism_q   <= mism_d;
    end
  end

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (err_inc),
    .count (err_count)
  );

`ifdef COUNT_CHECKER_WRAP_EN
  logic [7:0] wrap_q;

  // A wrap is a correctly predicted zero while already locked.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= '0;
    end else if (in_valid && (state_q == StLocked) && match && (in_count == '0)) begin
      wrap_q <= wrap_q + 8'd1;
    end
  end

  assign wrap_count = wrap_q;
`endif

  assign locked   = locked_q;
  assign mismatch = mism_q;
  assign expected = exp_q;

endmodule

// File: tb/tb_count_checker.sv
// Self-checking bench for count_checker: directed table, corner sequences, random vs. model.
module tb_count_checker;

  localparam int LockCnt = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic       rst, in_valid;
  logic [3:0] in_count;
  logic       locked, mismatch;
  logic [7:0] err_count;
  logic [3:0] expected;
`ifdef COUNT_CHECKER_WRAP_EN
  logic [7:0] wrap_count;
`endif

  // Narrow error counter instance for saturation.
  logic       rst2, in_valid2;
  logic [3:0] in_count2;
  logic       locked2, mismatch2;
  logic [1:0] err_count2;
  logic [3:0] expected2;
`ifdef COUNT_CHECKER_WRAP_EN
  logic [7:0] wrap_count2;
`endif

  count_checker u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .locked    (locked),
    .mismatch  (mismatch),
    .err_count (err_count),
`ifdef COUNT_CHECKER_WRAP_EN
    .wrap_count(wrap_count),
`endif
    .expected  (expected)
  );

  count_checker #(
    .ERR_W (2)
  ) u_dut2 (
    .clk       (clk),
    .rst       (rst2),
    .in_valid  (in_valid2),
    .in_count  (in_count2),
    .locked    (locked2),
    .mismatch  (mismatch2),
    .err_count (err_count2),
`ifdef COUNT_CHECKER_WRAP_EN
    .wrap_count(wrap_count2),
`endif
    .expected  (expected2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] c);
    rst      = r;
    in_valid = v;
    in_count = c;
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic r, input logic v, input logic [3:0] c);
    rst2      = r;
    in_valid2 = v;
    in_count2 = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int l, input int m, input int e, input int x);
    check({tag, ".locked"}, int'(locked), l);
    check({tag, ".mismatch"}, int'(mismatch), m);
    check({tag, ".err_count"}, int'(err_count), e);
    check({tag, ".expected"}, int'(expected), x);
  endtask

  typedef struct {
    logic       r;
    logic       v;
    logic [3:0] c;
    int         l;
    int         m;
    int         e;
    int         x;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit v, input int c, input int l, input int m,
                              input int e, input int x);
    vec_t t;
    t.r = r;
    t.v = v;
    t.c = 4'(c);
    t.l = l;
    t.m = m;
    t.e = e;
    t.x = x;
    return t;
  endfunction

  // Reference model: tracks the previous sample and the length of the clean run.
  bit         m_have, m_locked, m_mism;
  logic [3:0] m_prev;
  int         m_streak, m_err, m_wrap;

  task automatic model(input bit r, input bit v, input logic [3:0] c);
    m_mism = 1'b0;
    if (r) begin
      m_have = 0; m_prev = '0; m_streak = 0; m_locked = 0; m_err = 0; m_wrap = 0;
    end else if (v) begin
      if (!m_have) begin
        m_have   = 1;
        m_streak = 0;
      end else if (c == 4'(m_prev + 1)) begin
        if (m_locked && c == 4'd0) m_wrap = (m_wrap + 1) % 256;
        m_streak++;
        if (m_streak >= LockCnt) m_locked = 1;
      end else begin
        if (m_locked) begin
          m_mism = 1;
          if (m_err < 255) m_err++;
        end
        m_locked = 0;
        m_streak = 0;
      end
      m_prev = c;
    end
  endtask

  vec_t tbl[17];

  initial begin
    logic [3:0] cur, c, x, brk;
    bit         r, v;
    int         sel, want;

    rst = 1'b1; in_valid = 1'b0; in_count = '0;
    rst2 = 1'b1; in_valid2 = 1'b0; in_count2 = '0;

    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 5, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 5, 0, 0, 0, 6);
    tbl[3]  = mk(0, 1, 6, 0, 0, 0, 7);
    tbl[4]  = mk(0, 1, 7, 0, 0, 0, 8);
    tbl[5]  = mk(0, 1, 8, 1, 0, 0, 9);
    tbl[6]  = mk(0, 1, 9, 1, 0, 0, 10);
    tbl[7]  = mk(0, 1, 3, 0, 1, 1, 4);
    tbl[8]  = mk(0, 0, 7, 0, 0, 1, 4);
    tbl[9]  = mk(0, 1, 4, 0, 0, 1, 5);
    tbl[10] = mk(0, 1, 5, 0, 0, 1, 6);
    tbl[11] = mk(0, 1, 6, 1, 0, 1, 7);
    tbl[12] = mk(0, 1, 6, 0, 1, 2, 7);  // stalled counter
    tbl[13] = mk(0, 1, 7, 0, 0, 2, 8);
    tbl[14] = mk(0, 1, 8, 0, 0, 2, 9);
    tbl[15] = mk(0, 1, 9, 1, 0, 2, 10);
    tbl[16] = mk(0, 0, 2, 1, 0, 2, 10);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].c);
      check_all($sformatf("tbl%0d", i), tbl[i].l, tbl[i].m, tbl[i].e, tbl[i].x);
    end

    // Long idle gap while locked.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      check_all("idle", 1, 0, 2, 10);
    end
    drive(1'b0, 1'b1, 4'd10);
    check_all("after_idle", 1, 0, 2, 11);

    // Wrap through 15 -> 0.
    for (int i = 11; i <= 14; i++) begin
      drive(1'b0, 1'b1, 4'(i));
      check_all("pre_wrap", 1, 0, 2, (i + 1) % 16);
    end
    drive(1'b0, 1'b1, 4'd15);
    check_all("wrap15", 1, 0, 2, 0);
    drive(1'b0, 1'b1, 4'd0);
    check_all("wrap0", 1, 0, 2, 1);
    drive(1'b0, 1'b1, 4'd1);
    check_all("wrap1", 1, 0, 2, 2);
`ifdef COUNT_CHECKER_WRAP_EN
    check("wrap_count", int'(wrap_count), 1);
`endif

    // Reset with a wrong sample while locked.
    drive(1'b1, 1'b1, 4'd9);
    check_all("rst_mid", 0, 0, 0, 0);
`ifdef COUNT_CHECKER_WRAP_EN
    check("wrap_rst", int'(wrap_count), 0);
`endif
    drive(1'b0, 1'b1, 4'd9);
    check_all("post_rst0", 0, 0, 0, 10);
    drive(1'b0, 1'b1, 4'd10);
    check_all("post_rst1", 0, 0, 0, 11);
    drive(1'b0, 1'b1, 4'd11);
    check_all("post_rst2", 0, 0, 0, 12);
    drive(1'b0, 1'b1, 4'd12);
    check_all("post_rst3", 1, 0, 0, 13);
    in_valid = 1'b0;

    // Saturation on the 2-bit error counter.
    drive2(1'b1, 1'b0, 4'd0);
    x = 4'd0;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) drive2(1'b0, 1'b1, 4'(x + 4'(k)));
      check($sformatf("sat%0d.locked", i), int'(locked2), 1);
      brk = 4'(x + 4'd8);
      drive2(1'b0, 1'b1, brk);
      want = (i + 1 > 3) ? 3 : i + 1;
      check($sformatf("sat%0d.mismatch", i), int'(mismatch2), 1);
      check($sformatf("sat%0d.err", i), int'(err_count2), want);
      check($sformatf("sat%0d.unlock", i), int'(locked2), 0);
      drive2(1'b0, 1'b0, 4'd0);
      check($sformatf("sat%0d.pulse", i), int'(mismatch2), 0);
      x = 4'(brk + 4'd2);
    end
    rst2 = 1'b1;

    // Randomized run against the model.
    drive(1'b1, 1'b0, 4'd0);
    model(1'b1, 1'b0, 4'd0);
    cur = 4'($urandom_range(0, 15));
    for (int n = 0; n < 2000; n++) begin
      sel = $urandom_range(0, 99);
      r = 1'b0;
      v = 1'b1;
      c = 4'(cur + 4'd1);
      if (sel < 2) begin
        r = 1'b1;
        v = 1'($urandom_range(0, 1));
        c = 4'($urandom_range(0, 15));
      end else if (sel < 15) begin
        v = 1'b0;
        c = 4'($urandom_range(0, 15));
      end else if (sel < 22) begin
        c = 4'($urandom_range(0, 15));
      end else if (sel < 27) begin
        c = cur;
      end
      if (v && !r) cur = c;
      drive(r, v, c);
      model(r, v, c);
      check_all($sformatf("rnd%0d", n), int'(m_locked), int'(m_mism), m_err,
                m_have ? int'(4'(m_prev + 4'd1)) : 0);
`ifdef COUNT_CHECKER_WRAP_EN
      check($sformatf("rnd%0d.wrap", n), int'(wrap_count), m_wrap);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
